bg_scroll_flash_draw: RTL and testbench

//  Parametrised VGA background generator, successor to the fixed-border background drawer.

---
 rtl/bg_scroll_flash_draw.sv | 130 +++++++++++++
 tb/tb_bg_scroll_flash_draw.sv | 194 +++++++++++++++++++
 2 files changed

// File: rtl/bg_scroll_flash_draw.sv
// rtl/bg_scroll_flash_draw.sv - VGA background layer: sky, border bands, scrolling striped ground, flashing borders
module bg_scroll_flash_draw #(
  parameter int         X_FRAME       = 640,
  parameter int         Y_FRAME       = 480,
  parameter int         TOP_BAND_H    = 8,
  parameter int         FLOOR_Y       = 411,
  parameter int         FLOOR_H       = 8,
  parameter int         STRIPE_PERIOD = 32,
  parameter int         FLASH_FRAMES  = 16,
  parameter logic [7:0] SKY_RGB       = 8'h9F,
  parameter logic [7:0] BORDER_RGB    = 8'h1F,
  parameter logic [7:0] FLASH_RGB     = 8'hE0,
  parameter logic [7:0] GROUND_A_RGB  = 8'h4C,
  parameter logic [7:0] GROUND_B_RGB  = 8'h28
) (
  input  logic        clk,
  input  logic        resetN,
  input  logic [10:0] pixelX,
  input  logic [10:0] pixelY,
  input  logic        startOfFrame,
  input  logic        scrollEn,
  input  logic [3:0]  scrollSpeed,
  input  logic        flashReq,
  output logic [7:0]  BG_RGB,
  output logic        boardersDrawReq,
  output logic        flashActive
);

  localparam int SW = $clog2(STRIPE_PERIOD);
  localparam int CW = $clog2(FLASH_FRAMES + 1);
  // Phase bit of the flash counter; falls back to the MSB for tiny counters.
  localparam int PB = (CW > 2) ? 2 : CW - 1;

  localparam logic [10:0] X_LIM     = 11'(X_FRAME);
  localparam logic [10:0] Y_LIM     = 11'(Y_FRAME);
  localparam logic [10:0] TOP_LIM   = 11'(TOP_BAND_H);
  localparam logic [10:0] FLOOR_LO  = 11'(FLOOR_Y);
  localparam logic [10:0] GROUND_LO = 11'(FLOOR_Y + FLOOR_H);
  localparam logic [CW-1:0] CNT_LOAD = CW'(FLASH_FRAMES);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);

  typedef enum logic {IDLE, FLASH} state_t;

  state_t        state;
  logic [CW-1:0] flash_cnt;
  logic [SW-1:0] scroll_off;
  logic [SW-1:0] stripe_pos;
  logic [7:0]    border_col;
  logic [7:0]    ground_col;
  logic          outside, in_border, in_ground;

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      scroll_off <= '0;
    end else if (startOfFrame && scrollEn) begin
      scroll_off <= scroll_off + SW'(scrollSpeed);
    end
  end

  // A retrigger reloads the counter even on the frame that would end the flash.
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      state       <= IDLE;
      flash_cnt   <= '0;
      flashActive <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (flashReq) begin
            state       <= FLASH;
            flash_cnt   <= CNT_LOAD;
            flashActive <= 1'b1;
          end
        end
        FLASH: begin
          if (flashReq) begin
            flash_cnt <= CNT_LOAD;
          end else if (startOfFrame) begin
            if (flash_cnt <= CNT_ONE) begin
              state       <= IDLE;
              flash_cnt   <= '0;
              flashActive <= 1'b0;
            end else begin
              flash_cnt <= flash_cnt - CNT_ONE;
            end
          end
        end
        default: begin
          state       <= IDLE;
          flash_cnt   <= '0;
          flashActive <= 1'b0;
        end
      endcase
    end
  end

  always_comb begin
    border_col = BORDER_RGB;
    if (state == FLASH && !flash_cnt[PB]) begin
      border_col = FLASH_RGB;
    end
  end

  assign stripe_pos = pixelX[SW-1:0] + scroll_off;
  assign ground_col = stripe_pos[SW-1] ? GROUND_B_RGB : GROUND_A_RGB;

  assign outside   = (pixelX >= X_LIM) || (pixelY >= Y_LIM);
  assign in_border = (pixelY < TOP_LIM) || ((pixelY >= FLOOR_LO) && (pixelY < GROUND_LO));
  assign in_ground = (pixelY >= GROUND_LO);

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      BG_RGB          <= 8'h00;
      boardersDrawReq <= 1'b0;
    end else if (outside) begin
      BG_RGB          <= 8'h00;
      boardersDrawReq <= 1'b0;
    end else if (in_border) begin
      BG_RGB          <= border_col;
      boardersDrawReq <= 1'b1;
    end else if (in_ground) begin
      BG_RGB          <= ground_col;
      boardersDrawReq <= 1'b0;
    end else begin
      BG_RGB          <= SKY_RGB;
      boardersDrawReq <= 1'b0;
    end
  end

endmodule

// File: tb/tb_bg_scroll_flash_draw.sv
// tb/tb_bg_scroll_flash_draw.sv - scoreboard bench for bg_scroll_flash_draw
module tb_bg_scroll_flash_draw;

  logic        clk = 1'b0;
  logic        resetN;
  logic [10:0] pixelX, pixelY;
  logic        startOfFrame, scrollEn, flashReq;
  logic [3:0]  scrollSpeed;
  logic [7:0]  BG_RGB;
  logic        boardersDrawReq, flashActive;

  typedef struct {
    logic [7:0] rgb;
    logic       req;
    logic       act;
    string      tag;
  } exp_t;

  exp_t exp_q[$];
  logic probe = 1'b0;
  logic probe_d = 1'b0;
  int   compared = 0;
  int   mismatched = 0;

  bg_scroll_flash_draw dut (
    .clk            (clk),
    .resetN         (resetN),
    .pixelX         (pixelX),
    .pixelY         (pixelY),
    .startOfFrame   (startOfFrame),
    .scrollEn       (scrollEn),
    .scrollSpeed    (scrollSpeed),
    .flashReq       (flashReq),
    .BG_RGB         (BG_RGB),
    .boardersDrawReq(boardersDrawReq),
    .flashActive    (flashActive)
  );

  always #5 clk = ~clk;

  always @(posedge clk) probe_d <= probe;

  task automatic chk(input string tag, input int act, input int exp);
    compared++;
    if (act != exp) begin
      mismatched++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  // Monitor: one registered result per probed pixel.
  always @(negedge clk) begin
    if (probe_d) begin
      if (exp_q.size() == 0) begin
        compared++;
        mismatched++;
        $display("FAIL monitor: output with empty scoreboard");
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        compared++;
        if (BG_RGB !== e.rgb || boardersDrawReq !== e.req || flashActive !== e.act) begin
          mismatched++;
          $display("FAIL %s: got rgb=%h req=%b act=%b expected rgb=%h req=%b act=%b",
                   e.tag, BG_RGB, boardersDrawReq, flashActive, e.rgb, e.req, e.act);
        end
      end
    end
  end

  task automatic pix(input int x, input int y, input logic [7:0] rgb,
                     input logic req, input logic act, input string tag);
    exp_t e;
    @(posedge clk); #1;
    pixelX = 11'(x);
    pixelY = 11'(y);
    e.rgb = rgb; e.req = req; e.act = act; e.tag = tag;
    exp_q.push_back(e);
    probe = 1'b1;
    @(posedge clk); #1;
    probe = 1'b0;
  endtask

  task automatic frames(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1 startOfFrame = 1'b1;
      @(posedge clk); #1 startOfFrame = 1'b0;
    end
  endtask

  task automatic flash_pulse();
    @(posedge clk); #1 flashReq = 1'b1;
    @(posedge clk); #1 flashReq = 1'b0;
  endtask

  initial begin
    resetN = 1'b0;
    pixelX = '0; pixelY = '0;
    startOfFrame = 1'b0; scrollEn = 1'b0; flashReq = 1'b0; scrollSpeed = 4'd0;
    repeat (3) @(posedge clk);
    #2;
    chk("reset_rgb", int'(BG_RGB), 0);
    chk("reset_req", int'(boardersDrawReq), 0);
    chk("reset_act", int'(flashActive), 0);
    @(negedge clk) resetN = 1'b1;

    // Region sweep at offset 0
    pix(10, 0,   8'h1F, 1, 0, "top_y0");
    pix(10, 7,   8'h1F, 1, 0, "top_y7");
    pix(10, 8,   8'h9F, 0, 0, "sky_y8");
    pix(10, 200, 8'h9F, 0, 0, "sky_y200");
    pix(10, 411, 8'h1F, 1, 0, "floor_y411");
    pix(10, 418, 8'h1F, 1, 0, "floor_y418");
    pix(10, 419, 8'h4C, 0, 0, "ground_y419");
    pix(10, 450, 8'h4C, 0, 0, "ground_y450");
    pix(10, 480, 8'h00, 0, 0, "outside_y480");

    // Stripe boundaries
    pix(15,  450, 8'h4C, 0, 0, "stripe_x15");
    pix(16,  450, 8'h28, 0, 0, "stripe_x16");
    pix(32,  450, 8'h4C, 0, 0, "stripe_x32");
    pix(639, 450, 8'h28, 0, 0, "stripe_x639");
    pix(700, 450, 8'h00, 0, 0, "outside_x700");

    // Scrolling: 3 frames at speed 5 -> offset 15
    scrollEn = 1'b1; scrollSpeed = 4'd5;
    frames(3);
    chk("scroll_off_15", int'(dut.scroll_off), 15);
    pix(0, 450, 8'h4C, 0, 0, "scroll15_x0");
    pix(1, 450, 8'h28, 0, 0, "scroll15_x1");
    frames(3);
    chk("scroll_off_30", int'(dut.scroll_off), 30);
    pix(1, 450, 8'h28, 0, 0, "scroll30_x1");
    pix(2, 450, 8'h4C, 0, 0, "scroll30_x2");
    scrollEn = 1'b0;
    frames(1);
    chk("scroll_hold", int'(dut.scroll_off), 30);
    scrollEn = 1'b1;
    frames(1);
    chk("scroll_wrap_3", int'(dut.scroll_off), 3);
    pix(12, 450, 8'h4C, 0, 0, "scroll3_x12");
    pix(13, 450, 8'h28, 0, 0, "scroll3_x13");
    scrollEn = 1'b0;

    // Flash: 16 frames, phase bit 2 of the counter
    flash_pulse();
    chk("flash_cnt_load", int'(dut.flash_cnt), 16);
    pix(10, 0, 8'hE0, 1, 1, "flash_on_16");
    frames(4);
    chk("flash_cnt_12", int'(dut.flash_cnt), 12);
    pix(10, 0, 8'h1F, 1, 1, "flash_off_12");
    pix(10, 450, 8'h4C, 0, 1, "flash_ground");
    frames(12);
    chk("flash_cnt_done", int'(dut.flash_cnt), 0);
    pix(10, 0, 8'h1F, 1, 0, "flash_idle");

    // Retrigger on the exiting frame
    flash_pulse();
    frames(15);
    chk("flash_cnt_1", int'(dut.flash_cnt), 1);
    pix(10, 0, 8'hE0, 1, 1, "flash_cnt1");
    @(posedge clk); #1 startOfFrame = 1'b1; flashReq = 1'b1;
    @(posedge clk); #1 startOfFrame = 1'b0; flashReq = 1'b0;
    chk("retrigger_cnt", int'(dut.flash_cnt), 16);
    pix(10, 0, 8'hE0, 1, 1, "retrigger_px");

    // Async reset mid-flash, offset 20
    scrollEn = 1'b1; scrollSpeed = 4'd15;
    frames(1);
    scrollSpeed = 4'd2;
    frames(1);
    scrollEn = 1'b0;
    chk("pre_reset_off", int'(dut.scroll_off), 20);
    chk("pre_reset_cnt", int'(dut.flash_cnt), 14);
    pix(10, 0, 8'h1F, 1, 1, "pre_reset_px");
    @(negedge clk); #2;
    resetN = 1'b0;
    #1;
    chk("async_rgb", int'(BG_RGB), 0);
    chk("async_req", int'(boardersDrawReq), 0);
    chk("async_act", int'(flashActive), 0);
    chk("async_off", int'(dut.scroll_off), 0);
    chk("async_cnt", int'(dut.flash_cnt), 0);
    chk("async_state", int'(dut.state), 0);
    @(negedge clk) resetN = 1'b1;
    pix(12, 450, 8'h4C, 0, 0, "post_reset_x12");

    repeat (3) @(posedge clk);
    chk("scoreboard_drained", exp_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
